// File: rtl/led_row_scheduler.sv
// HUB75 BCM row/plane scheduler: shifts the next row/plane during display, then blank/latch/unblank.
// Define LED_SCHED_STATS_EN to build the display-overrun counter driving stall_count.
module led_row_scheduler #(
   parameter int ADDR_BITS  = 5,
   parameter int PLANES     = 4,
   parameter int BASE_TICKS = 8,
   localparam int PB        = (PLANES > 1) ? $clog2(PLANES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   output logic                 shift_req,
   output logic [ADDR_BITS-1:0] shift_addr,
   output logic [PB-1:0]        shift_plane,
   input  logic                 shift_ack,
   input  logic                 shift_done,
   output logic                 led_blank,
   output logic                 led_latch,
   output logic [ADDR_BITS-1:0] led_addr,
   output logic [PB-1:0]        disp_plane,
   output logic                 frame_start,
   output logic [15:0]          stall_count
);
   localparam int TW = $clog2(BASE_TICKS) + PLANES;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_SHIFT, S_WAIT, S_BLANK, S_LATCH, S_UNBLANK, S_DRAIN
   } state_t;

   state_t               state, state_n;
   logic [ADDR_BITS-1:0] row, row_inc, row_src;
   logic [PB-1:0]        plane, plane_inc, plane_src;
   logic [TW-1:0]        timer;
   logic                 timer_last;

   // The timer holds T in the unblank cycle itself, so the final display cycle is the one where it reads 1.
   assign timer_last = (timer <= TW'(1));

   always_comb begin
      plane_inc = plane + PB'(1);
      row_inc   = row;
      if (plane == PB'(PLANES - 1)) begin
         plane_inc = '0;
         row_inc   = row + ADDR_BITS'(1);
      end
      row_src   = row;
      plane_src = plane;
      if (state == S_IDLE) begin
         row_src   = '0;
         plane_src = '0;
      end else if (state == S_UNBLANK) begin
         row_src   = row_inc;
         plane_src = plane_inc;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (enable) state_n = S_REQ;
         S_REQ:     if (shift_ack) state_n = S_SHIFT;
         S_SHIFT:   if (shift_done) state_n = S_WAIT;
         S_WAIT:    if (timer_last) state_n = S_BLANK;
         S_BLANK:   state_n = S_LATCH;
         S_LATCH:   state_n = S_UNBLANK;
         S_UNBLANK: state_n = enable ? S_REQ : S_DRAIN;
         S_DRAIN:   if (timer_last) state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         row         <= '0;
         plane       <= '0;
         timer       <= '0;
         shift_req   <= 1'b0;
         shift_addr  <= '0;
         shift_plane <= '0;
         led_blank   <= 1'b1;
         led_latch   <= 1'b0;
         led_addr    <= '0;
         disp_plane  <= '0;
         frame_start <= 1'b0;
      end else begin
         state     <= state_n;
         row       <= row_src;
         plane     <= plane_src;
         shift_req <= (state_n == S_REQ);
         if (state_n == S_REQ && state != S_REQ) begin
            shift_addr  <= row_src;
            shift_plane <= plane_src;
         end
         led_latch   <= (state_n == S_LATCH);
         frame_start <= (state_n == S_LATCH) && (shift_addr == '0) && (shift_plane == '0);
         if (state_n == S_LATCH) begin
            led_addr   <= shift_addr;
            disp_plane <= shift_plane;
         end
         if (state_n == S_UNBLANK)
            led_blank <= 1'b0;
         else if (state_n inside {S_BLANK, S_LATCH, S_IDLE})
            led_blank <= 1'b1;
         if (state_n == S_UNBLANK)
            timer <= TW'(BASE_TICKS) << disp_plane;
         else if (timer != '0)
            timer <= timer - TW'(1);
      end
   end

`ifdef LED_SCHED_STATS_EN
   logic        overrun;
   logic [15:0] stall_q;

   assign overrun = (state == S_SHIFT) && (timer == '0) && !led_blank;

   always_ff @(posedge clk) begin
      if (reset)
         stall_q <= '0;
      else if (overrun && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_count = stall_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_led_row_scheduler.sv
// Scoreboard bench for led_row_scheduler: random shift-engine timing against a position/BCM-timing model.
module tb_led_row_scheduler;
   localparam int ADDR_BITS  = 5;
   localparam int PLANES     = 4;
   localparam int BASE_TICKS = 8;
   localparam int PB         = (PLANES > 1) ? $clog2(PLANES) : 1;
   localparam int NPOS       = (1 << ADDR_BITS) * PLANES;
   localparam logic [33:0] RESET_VEC = 34'h2_0000_0000;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 enable = 1'b0;
   logic                 shift_ack = 1'b0;
   logic                 shift_done = 1'b0;
   logic                 shift_req, led_blank, led_latch, frame_start;
   logic [ADDR_BITS-1:0] shift_addr, led_addr;
   logic [PB-1:0]        shift_plane, disp_plane;
   logic [15:0]          stall_count;

   led_row_scheduler #(.ADDR_BITS(ADDR_BITS), .PLANES(PLANES), .BASE_TICKS(BASE_TICKS)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .shift_req(shift_req), .shift_addr(shift_addr), .shift_plane(shift_plane),
      .shift_ack(shift_ack), .shift_done(shift_done),
      .led_blank(led_blank), .led_latch(led_latch), .led_addr(led_addr),
      .disp_plane(disp_plane), .frame_start(frame_start), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference-model and scoreboard state
   int  model_idx = 0;
   int  exp_latch_q[$];
   int  latch_count = 0;
   int  frame_pulses = 0;
   int  exp_frames = 0;
   int  exp_stall = 0;
   int  cur_t = 0;
   int  run_lat = 0;
   bit  run_has_req = 0;
   bit  mon_en = 0;
   bit  chk_gap = 0;
   bit  resp_en = 0;
   bit  resp_busy = 0;
   bit  hold_arm = 0;
   bit  stretch_arm = 0;
   bit  drop_arm = 0;
   bit  drop_done = 0;
   bit  ack_seen = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [33:0] outs();
      return {led_blank, led_latch, shift_req, frame_start, led_addr, disp_plane,
              shift_addr, shift_plane, stall_count};
   endfunction

   task automatic wait_latches(input int target, input int budget, input string name);
      int n = 0;
      while (latch_count < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, longint'(latch_count >= target), 1);
   endtask

   task automatic wait_blank(input logic level, input int budget, input string name);
      int n = 0;
      while (led_blank != level && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, longint'(led_blank), longint'(level));
   endtask

   always @(posedge clk) ack_seen <= shift_ack && shift_req;

   // Shift-engine model: acks after a random delay, pulses done a random number of cycles after the ack.
   initial begin : responder
      int a, d;
      forever begin
         @(negedge clk);
         if (resp_en && shift_req) begin
            resp_busy = 1;
            a = $urandom_range(0, 2);
            d = $urandom_range(1, 3);
            if (hold_arm) begin
               a = 50;
               hold_arm = 0;
            end
            if (stretch_arm && shift_plane == PB'(1)) begin
               d = 200;
               stretch_arm = 0;
            end
            run_lat = a + d + 3;
            run_has_req = 1;
            repeat (a) @(negedge clk);
            shift_ack = 1'b1;
            @(negedge clk);
            shift_ack = 1'b0;
            if (drop_arm) begin
               enable = 1'b0;
               drop_arm = 0;
               drop_done = 1;
            end
            repeat (d - 1) @(negedge clk);
            shift_done = 1'b1;
            @(negedge clk);
            shift_done = 1'b0;
            resp_busy = 0;
         end
      end
   end

   initial begin : monitor
      bit prev_req = 0;
      bit prev_blank = 1;
      bit had_run = 0;
      int low_len = 0;
      int high_len = 0;
      int p, exp_run;
      logic [ADDR_BITS+PB-1:0] held_req = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (ack_seen) check("req_drop_after_ack", longint'(shift_req), 0);
            if (shift_req && !prev_req) begin
               check("req_addr", longint'(shift_addr), longint'(model_idx / PLANES));
               check("req_plane", longint'(shift_plane), longint'(model_idx % PLANES));
               exp_latch_q.push_back(model_idx);
               model_idx = (model_idx + 1) % NPOS;
               held_req = {shift_addr, shift_plane};
            end else if (shift_req) begin
               check("req_hold", longint'({shift_addr, shift_plane}), longint'(held_req));
            end
            if (led_blank) begin
               if (!prev_blank) begin
                  exp_run = (run_has_req && run_lat > cur_t) ? run_lat : cur_t;
                  check("blank_low_len", longint'(low_len), longint'(exp_run));
`ifdef LED_SCHED_STATS_EN
                  if (exp_run > cur_t) exp_stall += exp_run - cur_t - 1;
`endif
                  check("stall_count", longint'(stall_count), longint'(exp_stall));
                  high_len = 0;
                  had_run = 1;
               end else begin
                  high_len++;
               end
            end else begin
               if (prev_blank) begin
                  if (chk_gap && had_run) check("blank_gap_len", longint'(high_len + 1), 2);
                  low_len = 0;
                  run_has_req = 0;
               end
               low_len++;
            end
            if (led_latch) begin
               latch_count++;
               if (chk_gap && had_run) check("latch_slot", longint'(high_len), 1);
               check("latch_pending", longint'(exp_latch_q.size()), 1);
               if (exp_latch_q.size() > 0) begin
                  p = exp_latch_q.pop_front();
                  check("latch_addr", longint'(led_addr), longint'(p / PLANES));
                  check("latch_plane", longint'(disp_plane), longint'(p % PLANES));
                  check("frame_start", longint'(frame_start), longint'(p == 0));
                  if (p == 0) exp_frames++;
                  cur_t = BASE_TICKS << (p % PLANES);
               end
            end
            if (frame_start) frame_pulses++;
         end else begin
            had_run = 0;
         end
         prev_req = shift_req;
         prev_blank = led_blank;
      end
   end

   initial begin : stimulus
      int n;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      mon_en = 1;
      repeat (100) begin
         @(negedge clk);
         check("idle_outputs", longint'(outs()), longint'(RESET_VEC));
      end

      // free-running scan past one full frame, with a held ack and one stretched plane-0 display
      chk_gap = 1;
      hold_arm = 1;
      stretch_arm = 1;
      resp_en = 1;
      enable = 1'b1;
      wait_latches(NPOS + 8, 20000, "frame_progress");
      check("frame_pulse_count", longint'(frame_pulses), longint'(exp_frames));
      check("frames_seen", longint'(exp_frames), 2);

      // enable drops mid-shift: swap and full display complete, then the block drains to idle
      chk_gap = 0;
      drop_arm = 1;
      n = 0;
      while (!drop_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drop_reached_shift", longint'(drop_done), 1);
      wait_latches(latch_count + 1, 300, "drain_swap_latch");
      wait_blank(1'b0, 50, "drain_unblank");
      wait_blank(1'b1, 300, "drain_blank");
      repeat (30) begin
         @(negedge clk);
         check("drain_idle", longint'({shift_req, led_blank, led_latch}), 3'b010);
      end

      // re-enable from idle restarts at (0,0)
      model_idx = 0;
      enable = 1'b1;
      wait_latches(latch_count + 3, 800, "reenable_progress");
      resp_en = 0;
      n = 0;
      while (resp_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("responder_idle", longint'(resp_busy), 0);
      enable = 1'b0;

      // reset while in the shift state, with done landing on the following cycle
      mon_en = 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_latch_q.delete();
      model_idx = 0;
      exp_stall = 0;
      @(negedge clk);
      mon_en = 1;
      enable = 1'b1;
      n = 0;
      while (!shift_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reset_test_req", longint'(shift_req), 1);
      shift_ack = 1'b1;
      @(negedge clk);
      shift_ack = 1'b0;
      enable = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      shift_done = 1'b1;
      @(negedge clk);
      shift_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         check("post_reset_outputs", longint'(outs()), longint'(RESET_VEC));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
